fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning prefetch queue entries (power of 2, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset (word aligned).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port fetch_en  input  1  permits new instruction-memory reads when high.
REQ-006 SHALL have port mem_addr  output  32  byte address driven to instruction memory.
REQ-007 SHALL have port mem_rd  output  1  high in cycles where mem_instr is captured into the queue.
REQ-008 SHALL have port mem_instr  input  32  combinational read data for mem_addr, valid in the same cycle.
REQ-009 SHALL have port redirect  input  1  branch/jump redirect request.
REQ-010 SHALL have port redirect_pc  input  32  redirect target; bits [1:0] ignored.
REQ-011 SHALL have port instr_valid  output  1  queue head holds a valid instruction.
REQ-012 SHALL have port instr  output  32  queue-head instruction word.
REQ-013 SHALL have port instr_pc  output  32  byte address of queue-head instruction.
REQ-014 SHALL have port instr_ready  input  1  consumer accepts head when high with instr_valid.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  current number of occupied entries.

Function
REQ-016 SHALL hold a 32-bit fetch_pc register; mem_addr SHALL equal {fetch_pc[31:2],2'b00} combinationally.
REQ-017 SHALL define pop = instr_valid & instr_ready & ~redirect.
REQ-018 SHALL define push = fetch_en & ~redirect & (count < DEPTH | pop); mem_rd SHALL equal push.
REQ-019 On push, SHALL write {fetch_pc, mem_instr} at the tail and increment fetch_pc by 4 at the clock edge.
REQ-020 On pop, SHALL advance the head; instr/instr_pc SHALL present the new head in the following cycle.
REQ-021 Simultaneous push and pop SHALL leave count unchanged, including when count == DEPTH (full-with-pop accepted).
REQ-022 count SHALL never exceed DEPTH nor underflow below 0; push when full without pop SHALL NOT occur.
REQ-023 instr_valid SHALL equal (count != 0); instr/instr_pc SHALL be 0 when count == 0.
REQ-024 Fetch-to-output latency SHALL be 1 cycle: word pushed at edge N is visible at head after edge N if queue was empty.
REQ-025 fetch_pc SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0) with no error indication.
REQ-026 On redirect (any cycle, any occupancy), at the next edge: queue flushed (count=0), fetch_pc = {redirect_pc[31:2],2'b00}, no push, no pop.
REQ-027 Redirect SHALL take priority over push, pop and fetch_en; consecutive redirects SHALL each re-flush, last one wins.
REQ-028 First fetch of redirect target SHALL occur in the cycle after redirect; instr_valid for it SHALL rise 2 cycles after redirect asserted (if fetch_en high).
REQ-029 fetch_en low SHALL freeze fetch_pc and suppress push while pops continue to drain the queue.
REQ-030 Read/write pointers SHALL wrap modulo DEPTH without losing or duplicating entries.

Reset
REQ-031 While reset high, SHALL asynchronously force fetch_pc=RESET_PC, count=0, pointers=0, instr_valid=0, instr=0, instr_pc=0.
REQ-032 mem_rd SHALL be 0 while reset high; mem_addr SHALL equal RESET_PC.
REQ-033 Reset asserted mid-operation SHALL discard all queued entries; first fetch after release SHALL be at RESET_PC.

Verification
REQ-034 Reset release, fetch_en=1, instr_ready=1, memory word k = k -> instr_pc 0,4,8,... and instr 0,1,2,... one per cycle, instr_valid high from cycle 2.
REQ-035 instr_ready=0, fetch_en=1 for 10 cycles -> count saturates at DEPTH (4), mem_rd low once full, fetch_pc = 0x10; then ready=1 -> entries 0..3 pop in order, no gap or duplicate.
REQ-036 Queue full (count=4), redirect=1 with redirect_pc=0x23 for one cycle -> next cycle count=0, instr_valid=0, mem_addr=0x20; instr_pc=0x20 valid 2 cycles after redirect.
REQ-037 Full queue with instr_ready=1 and fetch_en=1 -> push and pop same cycle, count stays 4, mem_rd=1 each cycle.
REQ-038 Redirect to 0xFFFF_FFF8 -> fetched instr_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-039 reset pulsed mid-stream with count=3 -> outputs zero immediately (asynchronous), fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: groups the instruction-memory, redirect and consumer signals of the
// prefetch queue.
//   master : the fetch queue itself. It drives mem_addr, mem_rd, instr_valid, instr,
//            instr_pc and count.
//   slave  : the environment (memory, branch unit, decode). It drives fetch_en, mem_instr,
//            redirect, redirect_pc and instr_ready.
interface fetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic            fetch_en;
    logic [31:0]     mem_addr;
    logic            mem_rd;
    logic [31:0]     mem_instr;
    logic            redirect;
    logic [31:0]     redirect_pc;
    logic            instr_valid;
    logic [31:0]     instr;
    logic [31:0]     instr_pc;
    logic            instr_ready;
    logic [CntW-1:0] count;

    modport master (
        input  fetch_en, mem_instr, redirect, redirect_pc, instr_ready,
        output mem_addr, mem_rd, instr_valid, instr, instr_pc, count
    );

    modport slave (
        output fetch_en, mem_instr, redirect, redirect_pc, instr_ready,
        input  mem_addr, mem_rd, instr_valid, instr, instr_pc, count
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue. It reads one word per cycle from a
// combinational instruction memory into a DEPTH-entry FIFO of {pc, instr} pairs.
// A redirect flushes the queue and restarts fetching at the target.
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-high
//   bus   : fetch_queue_if.master (memory port, redirect, head-of-queue output, count)
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic [31:0] instr_q [DEPTH];
    logic [31:0] pc_q    [DEPTH];

    logic not_empty;
    logic push;
    logic pop;

    // The low two bits of the redirect target are dropped.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    assign not_empty = (count_q != '0);
    assign pop       = not_empty & bus.instr_ready & ~bus.redirect;
    // A full queue still accepts a word when the head leaves in the same cycle.
    // Gating with reset keeps mem_rd low while reset is held.
    assign push      = ~reset & bus.fetch_en & ~bus.redirect & ((count_q < Full) | pop);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (bus.redirect) begin
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + 32'd4;  // wraps modulo 2^32
                wr_ptr_d   = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: the entries are masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr_q] <= bus.mem_instr;
            pc_q[wr_ptr_q]    <= bus.mem_addr;
        end
    end

    assign bus.mem_addr    = {fetch_pc_q[31:2], 2'b00};
    assign bus.mem_rd      = push;
    assign bus.instr_valid = not_empty;
    assign bus.instr       = not_empty ? instr_q[rd_ptr_q] : 32'h0;
    assign bus.instr_pc    = not_empty ? pc_q[rd_ptr_q]    : 32'h0;
    assign bus.count       = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios followed by random stimulus. Every cycle the DUT
// outputs are compared against a queue-based reference model.
module tb_fetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int unsigned n_checks = 0;
    int unsigned n_bad    = 0;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory word at word index k holds the value k.
    assign bus.mem_instr = {2'b00, bus.mem_addr[31:2]};

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] m_pc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every output with the model, given the inputs currently applied.
    task automatic check_outputs(output logic e_push, output logic e_pop);
        logic vld;
        vld    = (mq.size() != 0);
        e_pop  = vld & bus.instr_ready & ~bus.redirect;
        e_push = ~reset & bus.fetch_en & ~bus.redirect & ((mq.size() < DEPTH) || e_pop);
        check_val("mem_addr", bus.mem_addr, {m_pc[31:2], 2'b00});
        check_val("mem_rd", 32'(bus.mem_rd), 32'(e_push));
        check_val("instr_valid", 32'(bus.instr_valid), 32'(vld));
        check_val("instr", bus.instr, vld ? mq[0].ins : 32'h0);
        check_val("instr_pc", bus.instr_pc, vld ? mq[0].pc : 32'h0);
        check_val("count", 32'(bus.count), mq.size());
    endtask

    // One cycle: apply inputs, check, advance the model across the edge. Starts at negedge.
    task automatic step(input logic en, input logic rdy, input logic redir,
                        input logic [31:0] rpc);
        logic p;
        logic q;
        bus.fetch_en    = en;
        bus.instr_ready = rdy;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        #1;
        check_outputs(p, q);
        @(posedge clk);
        if (redir) begin
            mq.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (q) mq.delete(0);
            if (p) begin
                mq.push_back('{pc: m_pc, ins: {2'b00, m_pc[31:2]}});
                m_pc = m_pc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    // Assert reset between edges so its effect is seen before any clock edge.
    task automatic reset_pulse(input int cycles);
        logic p;
        logic q;
        reset = 1'b1;
        #1;
        mq.delete();
        m_pc = RESET_PC;
        check_outputs(p, q);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        check_outputs(p, q);
        reset = 1'b0;
    endtask

    initial begin
        logic p;
        logic q;
        bus.fetch_en    = 1'b1;
        bus.instr_ready = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        m_pc            = RESET_PC;
        #1;
        check_outputs(p, q);
        @(negedge clk);
        reset = 1'b0;

        // Streaming fetch, one instruction per cycle.
        repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Saturate with the consumer stalled, then drain with push and pop together.
        reset_pulse(1);
        repeat (10) step(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (6) step(1'b0, 1'b1, 1'b0, 32'h0);

        // Redirect out of a full queue, with a misaligned target.
        repeat (5) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'h23);
        repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Fetch PC wraps through zero.
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Back-to-back redirects: the last target wins.
        step(1'b1, 1'b1, 1'b1, 32'h40);
        step(1'b1, 1'b1, 1'b1, 32'h80);
        repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Reset mid-stream with three entries queued.
        step(1'b1, 1'b0, 1'b1, 32'h100);
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
        reset_pulse(2);
        repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset_pulse(int'($urandom_range(1, 2)));
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                     $urandom_range(0, 15) == 0, $urandom);
            end
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
